// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and frame constants.
// Pure declarations, no timing of its own.
// Optional break/mark states exist only when UART_BREAK_EN is defined.
package uart_pkg;

  localparam logic [7:0] SYNC_CHAR  = 8'h55;
  localparam int         BREAK_BITS = 13;
  localparam int         DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
`ifdef UART_BREAK_EN
    ,
    ST_BREAK = 3'd5,
    ST_MARK  = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter that ticks for one cycle when a period ends.
// Latency: tick is asserted in the last cycle of a period loaded with P-1.
// No backpressure; the owner reloads on tick to start the next period.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Load has priority; otherwise count down and hold at zero (never wraps).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/uart_abr_tx.sv
// UART transmitter sending a data byte or the 0x55 ABR sync character.
// Latency: UxTX falls one cycle after start is sampled; frame 10P + 1 Done cycle.
// No backpressure: start is only sampled in Idle; inputs ignored while busy.
// Optional: define UART_BREAK_EN to precede sync frames with a 13P break and 1P mark.
module uart_abr_tx
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] brg,
  input  logic             start,
  input  logic             send_sync,
  input  logic [7:0]       din,
  output logic             UxTX,
  output logic             busy,
  output logic             UxTXIF
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] p_in;
  logic [DIV_W-1:0] p_reg;
  logic [DIV_W-1:0] load_val;
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;
  logic             accept;
  logic             load;
  logic             timer_en;
  logic             tick;
`ifdef UART_BREAK_EN
  logic [3:0]       brk_cnt;
`endif

  // A divisor of zero would give a zero-length bit; treat it as one cycle.
  assign p_in   = (brg == '0) ? ONE : brg;
  assign accept = (state == ST_IDLE) && start;

`ifdef UART_BREAK_EN
  assign timer_en = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP) ||
                    (state == ST_BREAK) || (state == ST_MARK);
`else
  assign timer_en = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
`endif

  // Each bit period reloads P-1; the first one uses the freshly captured divisor.
  assign load     = accept || tick;
  assign load_val = accept ? (p_in - ONE) : (p_reg - ONE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (timer_en),
    .load_val (load_val),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and output decode; outputs depend only on state and shift data.
  always_comb begin
    next_state = state;
    UxTX       = 1'b1;
    busy       = (state != ST_IDLE);
    UxTXIF     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
`ifdef UART_BREAK_EN
          next_state = send_sync ? ST_BREAK : ST_START;
`else
          next_state = ST_START;
`endif
        end
      end
`ifdef UART_BREAK_EN
      ST_BREAK: begin
        UxTX = 1'b0;
        if (tick && (brk_cnt == 4'(BREAK_BITS - 1))) next_state = ST_MARK;
      end
      ST_MARK: begin
        if (tick) next_state = ST_START;
      end
`endif
      ST_START: begin
        UxTX = 1'b0;
        if (tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        UxTX = shift[0];
        if (tick && (bit_cnt == 3'(DATA_BITS - 1))) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (tick) next_state = ST_DONE;
      end
      ST_DONE: begin
        UxTXIF     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame datapath: capture on acceptance, shift out LSB first at each data bit end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg   <= '0;
      shift   <= '0;
      bit_cnt <= '0;
`ifdef UART_BREAK_EN
      brk_cnt <= '0;
`endif
    end else if (accept) begin
      p_reg   <= p_in;
      shift   <= send_sync ? SYNC_CHAR : din;
      bit_cnt <= '0;
`ifdef UART_BREAK_EN
      brk_cnt <= '0;
`endif
    end else if (tick) begin
      if (state == ST_DATA) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef UART_BREAK_EN
      if (state == ST_BREAK) begin
        brk_cnt <= brk_cnt + 4'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_abr_tx.sv
// Testbench for uart_abr_tx: directed frames, expected waveforms queued per frame
// and checked by an independent line monitor.
module tb_uart_abr_tx;

  typedef struct {
    logic [7:0] dat;
    int         p;
    bit         brk;
    bit         chk_gap;
    int         abort_len;
  } exp_t;

`ifdef UART_BREAK_EN
  localparam bit BRK_ON = 1'b1;
`else
  localparam bit BRK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] brg = '0;
  logic        start = 1'b0;
  logic        send_sync = 1'b0;
  logic [7:0]  din = '0;
  logic        UxTX;
  logic        busy;
  logic        UxTXIF;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  bit   in_frame = 1'b0;

  always #5 clk = ~clk;

  uart_abr_tx #(.DIV_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .brg       (brg),
    .start     (start),
    .send_sync (send_sync),
    .din       (din),
    .UxTX      (UxTX),
    .busy      (busy),
    .UxTXIF    (UxTXIF)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input int p, input bit brk,
                              input bit gap, input int abort_len);
    exp_t e;
    e.dat = d; e.p = p; e.brk = brk; e.chk_gap = gap; e.abort_len = abort_len;
    return e;
  endfunction

  // One start pulse; inputs are scrambled right after acceptance to prove they are ignored.
  task automatic send(input logic [7:0] d, input logic s, input logic [15:0] b);
    @(negedge clk);
    din = d; send_sync = s; brg = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din = 8'($urandom);
    brg = 16'($urandom_range(0, 9));
    send_sync = 1'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy || in_frame || (sb_q.size() != 0)) && (i < 5000)) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check("idle_timeout", 32'(i >= 5000), 0);
  endtask

  // Line monitor: on each busy rise, pop the expected frame and compare cycle by cycle.
  initial begin
    exp_t e;
    logic exp_wave [0:4095];
    int   k, n, exp_len, req_len, wave_err, txif_cnt, txif_pos, idle_cnt;
    idle_cnt = 100;
    forever begin
      @(negedge clk);
      if (!busy) begin
        idle_cnt++;
      end else if (sb_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        n = 0;
        while (busy && n < 3000) begin
          @(negedge clk);
          n++;
        end
        idle_cnt = 1;
      end else begin
        in_frame = 1'b1;
        e = sb_q.pop_front();
        if (e.chk_gap) check("b2b_idle_gap", idle_cnt, 1);
        k = 0;
        if (e.brk) begin
          for (int i = 0; i < 13 * e.p; i++) begin exp_wave[k] = 1'b0; k++; end
          for (int i = 0; i < e.p; i++) begin exp_wave[k] = 1'b1; k++; end
        end
        for (int i = 0; i < e.p; i++) begin exp_wave[k] = 1'b0; k++; end
        for (int b = 0; b < 8; b++)
          for (int i = 0; i < e.p; i++) begin exp_wave[k] = e.dat[b]; k++; end
        for (int i = 0; i < e.p; i++) begin exp_wave[k] = 1'b1; k++; end
        exp_wave[k] = 1'b1; k++;
        exp_len = k;
        n = 0; wave_err = 0; txif_cnt = 0; txif_pos = -1;
        while (busy && n < 3000) begin
          if (n < exp_len && UxTX !== exp_wave[n]) wave_err++;
          if (UxTXIF) begin txif_cnt++; txif_pos = n; end
          n++;
          @(negedge clk);
        end
        idle_cnt = 1;
        req_len = (e.abort_len != 0) ? e.abort_len : exp_len;
        check("busy_len", n, req_len);
        check("wave_errs", wave_err, 0);
        if (e.abort_len != 0) begin
          check("abort_txif_cnt", txif_cnt, 0);
        end else begin
          check("txif_cnt", txif_cnt, 1);
          check("txif_pos", txif_pos, exp_len - 1);
        end
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_UxTX", UxTX, 1);
    check("rst_busy", busy, 0);
    check("rst_UxTXIF", UxTXIF, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // brg=4, 0xA3: bits 1,1,0,0,0,1,0,1; 41 busy cycles
    sb_q.push_back(mk(8'hA3, 4, 1'b0, 1'b0, 0));
    send(8'hA3, 1'b0, 16'd4);
    wait_idle();

    // brg=0 acts as 1; sync character regardless of din
    sb_q.push_back(mk(8'h55, 1, BRK_ON, 1'b0, 0));
    send(8'h00, 1'b1, 16'd0);
    wait_idle();

    // Inputs toggled throughout a brg=3 frame of 0x96
    sb_q.push_back(mk(8'h96, 3, 1'b0, 1'b0, 0));
    send(8'h96, 1'b0, 16'd3);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      start = ~start;
      din = 8'($urandom);
      brg = 16'($urandom_range(0, 9));
      send_sync = 1'($urandom);
    end
    start = 1'b0;
    wait_idle();

    // Reset after 15 busy cycles of a brg=4 frame
    sb_q.push_back(mk(8'hC5, 4, 1'b0, 1'b0, 15));
    send(8'hC5, 1'b0, 16'd4);
    repeat (14) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_UxTX", UxTX, 1);
    check("abort_busy", busy, 0);
    check("abort_UxTXIF", UxTXIF, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    sb_q.push_back(mk(8'h5A, 4, 1'b0, 1'b0, 0));
    send(8'h5A, 1'b0, 16'd4);
    wait_idle();

    // start held 100 cycles, brg=2: accepts every 22 cycles -> 5 frames
    for (int f = 0; f < 5; f++) sb_q.push_back(mk(8'h3C, 2, 1'b0, (f != 0), 0));
    @(negedge clk);
    din = 8'h3C; brg = 16'd2; send_sync = 1'b0; start = 1'b1;
    repeat (100) @(negedge clk);
    start = 1'b0;
    wait_idle();

`ifdef UART_BREAK_EN
    // Break-prefixed sync: 26 low, 2 high, then frame; 49 busy cycles
    sb_q.push_back(mk(8'h55, 2, 1'b1, 1'b0, 0));
    send(8'hFF, 1'b1, 16'd2);
    wait_idle();
`endif

    repeat (20) @(negedge clk);
    check("queue_left", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
